// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid bit, flush PC policy
// and saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned     DATA_W        = 32,
  parameter int unsigned     PC_W          = 32,
  parameter logic [PC_W-1:0] PC_RESET      = 32'h0000_3000,
  parameter int unsigned     EXC_W         = 5,
  parameter bit              FLUSH_KEEP_PC = 1'b1,
  parameter int unsigned     CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  input  logic              stall,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_STALL,
    ACT_LOAD
  } action_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  action_e action;
  logic    count_stall;
  logic    count_bubble;

  // Resolve the per-edge priority once: reset > flush > stall > load.
  always_comb begin
    // NOTE: default assignment first so every path writes action and no latch is inferred.
    action = ACT_LOAD;
    if (reset)      action = ACT_RESET;
    else if (flush) action = ACT_FLUSH;
    else if (stall) action = ACT_STALL;
  end

  assign count_stall  = (action == ACT_STALL);
  assign count_bubble = (action == ACT_FLUSH) || ((action == ACT_LOAD) && !in_valid);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    unique case (action)
      ACT_RESET: begin
        out_valid <= 1'b0;
        out_pc    <= PC_RESET;
        out_instr <= '0;
        out_exc   <= '0;
        out_bd    <= 1'b0;
      end
      ACT_FLUSH: begin
        out_valid <= 1'b0;
        out_instr <= '0;
        out_exc   <= '0;
        out_bd    <= 1'b0;
        if (!FLUSH_KEEP_PC) out_pc <= in_pc;
      end
      ACT_STALL: begin
        out_valid <= out_valid;
      end
      ACT_LOAD: begin
        out_valid <= in_valid;
        out_pc    <= in_pc;
        // A slot without a real instruction becomes a clean nop.
        out_instr <= in_valid ? in_instr : '0;
        out_exc   <= in_valid ? in_exc : '0;
        out_bd    <= in_valid & in_bd;
      end
      default: begin
        out_valid <= 1'b0;
      end
    endcase
  end

  // Counters: clear beats a same-edge increment, reset beats clear.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (count_stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (count_bubble && (bubble_cnt != CNT_MAX))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register. Generalises the F/D register: payload width, PC width, exception code and delay-slot flag are all configurable.
- Adds an explicit valid bit, a selectable PC policy on flush, and saturating stall/bubble performance counters.
- One instance sits at each stage boundary of the 5-stage MIPS pipeline (F/D, D/E, E/M, M/W).
- Hazard unit drives stall and flush; the downstream stage consumes the out_* fields.

Parameters:
- DATA_W, 32, payload (instruction) width.
- PC_W, 32, PC field width.
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- EXC_W, 5, exception code width.
- FLUSH_KEEP_PC, 1: 1 = flush holds the current out_pc; 0 = flush loads in_pc.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream slot holds a real instruction.
- in_pc  in  PC_W  upstream PC.
- in_instr  in  DATA_W  upstream instruction.
- in_exc  in  EXC_W  upstream exception code (0 = none).
- in_bd  in  1  upstream instruction is in a branch delay slot.
- stall  in  1  hold the register contents.
- flush  in  1  insert a bubble.
- clr_cnt  in  1  synchronous clear of both counters.
- out_valid  out  1  registered valid.
- out_pc  out  PC_W  registered PC.
- out_instr  out  DATA_W  registered instruction; 0 (nop) whenever out_valid=0.
- out_exc  out  EXC_W  registered exception code.
- out_bd  out  1  registered delay-slot flag.
- stall_cnt  out  CNT_W  cycles spent stalled.
- bubble_cnt  out  CNT_W  bubbles inserted.

Behaviour:
- All outputs are registered. Latency is 1 cycle from in_* to out_*. No combinational path from any input to any output.
- Priority per edge: reset > flush > stall > load.
- reset:
  - out_valid=0, out_pc=PC_RESET, out_instr=0, out_exc=0, out_bd=0.
  - stall_cnt=0, bubble_cnt=0.
  - Mid-operation reset discards everything immediately; all other inputs are ignored that edge.
- flush (takes effect even when stall=1):
  - out_valid=0, out_instr=0, out_exc=0, out_bd=0.
  - out_pc holds its value if FLUSH_KEEP_PC=1; loads in_pc if FLUSH_KEEP_PC=0.
- stall (flush=0): every out_* field holds its value.
- load (stall=0, flush=0):
  - out_pc<=in_pc, out_valid<=in_valid, out_bd<=in_bd, out_exc<=in_exc.
  - out_instr<=in_instr if in_valid=1, else 0.
  - When in_valid=0, out_exc and out_bd are also forced to 0.
- stall_cnt:
  - +1 on every edge with stall=1, flush=0, reset=0.
  - Saturates at 2^CNT_W-1; no wrap-around.
- bubble_cnt:
  - +1 on every edge where out_valid is written 0 by a flush, or by a load with in_valid=0.
  - Saturates at 2^CNT_W-1. Reset edges do not count.
- clr_cnt: zeroes both counters. Beats same-edge increments; loses to reset. Pipeline fields are unaffected.
- stall and flush asserted together: the flush wins and counts as a bubble, not as a stall.
- Width rules: every field is independent. There is no arithmetic on the payload.

Test Plan:
- Reset, then load in_pc=32'h3004, in_instr=32'h2408_0001, in_valid=1 -> one edge later out_pc=32'h3004, out_instr=32'h2408_0001, out_valid=1. Out_* stays at its reset values until that edge.
- stall=1 for 3 cycles with changing inputs -> out_* frozen at the prior values; stall_cnt=3; bubble_cnt=0.
- stall=1 and flush=1 on the same edge, FLUSH_KEEP_PC=1, prior out_pc=32'h3008, in_pc=32'h300c -> out_valid=0, out_instr=0, out_exc=0, out_pc=32'h3008; bubble_cnt+1; stall_cnt unchanged. Repeat with FLUSH_KEEP_PC=0 -> out_pc=32'h300c.
- Load with in_valid=0, in_instr=32'hFFFF_FFFF, in_exc=5'd4, in_bd=1 -> out_valid=0, out_instr=0, out_exc=0, out_bd=0; bubble_cnt+1.
- CNT_W=4, hold stall=1 for 20 cycles -> stall_cnt sticks at 15. Then clr_cnt=1 with stall=1 -> stall_cnt=0 on that edge and 1 on the next.
- Reset asserted during a stalled sequence with counters non-zero -> next edge: out_pc=32'h3000, out_valid=0, both counters 0.
